// File: rtl/udma_tx_read_sched_if.sv
// Bundle of the channel-side and L2-side signals of the uDMA TX read scheduler.
// The ch_prio_i signal is present only when UDMA_TX_SCHED_PRIO_EN is defined.
interface udma_tx_read_sched_if #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int MAX_OUTST  = 4
);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic [N_CH-1:0]            ch_req_i;
  logic [N_CH*ADDR_WIDTH-1:0] ch_addr_i;
  logic [N_CH-1:0]            ch_gnt_o;
  logic [N_CH-1:0]            ch_valid_o;
  logic [DATA_WIDTH-1:0]      ch_data_o;
`ifdef UDMA_TX_SCHED_PRIO_EN
  logic [N_CH-1:0]            ch_prio_i;
`endif
  logic                       mem_req_o;
  logic [ADDR_WIDTH-1:0]      mem_addr_o;
  logic                       mem_gnt_i;
  logic                       mem_rvalid_i;
  logic [DATA_WIDTH-1:0]      mem_rdata_i;
  logic [CNT_W-1:0]           outst_o;
  logic                       err_o;

  // Environment side: channels and L2 memory
  modport master (
`ifdef UDMA_TX_SCHED_PRIO_EN
    output ch_prio_i,
`endif
    output ch_req_i, ch_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ch_gnt_o, ch_valid_o, ch_data_o, mem_req_o, mem_addr_o, outst_o, err_o
  );

  // Scheduler side
  modport slave (
`ifdef UDMA_TX_SCHED_PRIO_EN
    input  ch_prio_i,
`endif
    input  ch_req_i, ch_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ch_gnt_o, ch_valid_o, ch_data_o, mem_req_o, mem_addr_o, outst_o, err_o
  );
endinterface

// File: rtl/udma_tx_read_sched.sv
// Round-robin read scheduler sharing one L2 read port between N_CH TX channels.
// A tag FIFO remembers the owner of each in-flight read so in-order returns are
// steered back combinationally. Define UDMA_TX_SCHED_PRIO_EN to add ch_prio_i
// and restrict the round-robin scan to high-priority requesters when present.
module udma_tx_read_sched #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int MAX_OUTST  = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  udma_tx_read_sched_if.slave   bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] rr_ptr, lock_ch, scan_win, winner;
  logic [CH_W-1:0] tag_mem [MAX_OUTST];
  logic [PTR_W:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic            err;
  logic            full, empty, mem_req, push, pop, found;
  logic [N_CH-1:0] cand;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign mem_req = ~rst_i & (|bus.ch_req_i) & ~full;
  assign push    = mem_req & bus.mem_gnt_i;
  assign pop     = ~rst_i & bus.mem_rvalid_i & ~empty;

  // Candidate set: high-priority requesters only, when any exist
  always_comb begin
    cand = bus.ch_req_i;
`ifdef UDMA_TX_SCHED_PRIO_EN
    if (|(bus.ch_req_i & bus.ch_prio_i)) cand = bus.ch_req_i & bus.ch_prio_i;
`endif
  end

  // Round-robin scan from rr_ptr upward with wrap; the lock overrides it
  always_comb begin
    int unsigned idx;
    found    = 1'b0;
    scan_win = rr_ptr;
    idx      = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(rr_ptr) + i) % N_CH;
      if (!found && cand[idx]) begin
        found    = 1'b1;
        scan_win = CH_W'(idx);
      end
    end
    winner = (state == ST_LOCK && bus.ch_req_i[lock_ch]) ? lock_ch : scan_win;
  end

  // Lock is entered whenever a request is presented but not granted
  always_comb begin
    state_nxt = ST_ARB;
    if (mem_req && !bus.mem_gnt_i) state_nxt = ST_LOCK;
  end

  // Lock state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_ARB;
    else       state <= state_nxt;
  end

  // Arbitration pointer, locked channel, tag FIFO, count and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      lock_ch <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err     <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) tag_mem[i] <= '0;
    end else begin
      if (push) begin
        rr_ptr <= (winner == CH_W'(N_CH - 1)) ? '0 : winner + 1'b1;
        tag_mem[wr_ptr[PTR_W-1:0]] <= winner;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (mem_req && !bus.mem_gnt_i) lock_ch <= winner;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (bus.mem_rvalid_i && empty) err <= 1'b1;
    end
  end

  // Grant to the winner and steer returning data to the FIFO head owner
  always_comb begin
    bus.ch_gnt_o   = '0;
    bus.ch_valid_o = '0;
    if (push) bus.ch_gnt_o[winner] = 1'b1;
    if (pop)  bus.ch_valid_o[tag_mem[rd_ptr[PTR_W-1:0]]] = 1'b1;
  end

  assign bus.mem_req_o  = mem_req;
  assign bus.mem_addr_o = rst_i ? '0 : bus.ch_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.ch_data_o  = rst_i ? '0 : bus.mem_rdata_i;
  assign bus.outst_o    = count;
  assign bus.err_o      = err;
endmodule

// File: tb/tb_udma_tx_read_sched.sv
// Directed bench for udma_tx_read_sched (N_CH=4, MAX_OUTST=4): a vector table
// stepped one clock per entry, plus hand sequences for lock and priority.
module tb_udma_tx_read_sched;
  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int AW   = 19;
  localparam int MO   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udma_tx_read_sched_if #(.N_CH(N_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTST(MO)) bus ();

  udma_tx_read_sched #(.N_CH(N_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTST(MO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [3:0]  e_gnt;
    logic [3:0]  e_valid;
    logic        e_mreq;
    logic        a_chk;
    logic [18:0] e_addr;
    logic [2:0]  e_outst;
    logic        e_err;
  } vec_t;

  localparam logic [18:0] A0 = 19'h010, A1 = 19'h020, A2 = 19'h100, A3 = 19'h040;

  int checks = 0;
  int errors = 0;
  vec_t v [$];

  function automatic vec_t mk(input logic r, input logic [3:0] req, input logic g, input logic rv,
                              input logic [3:0] eg, input logic [3:0] ev, input logic em,
                              input logic ac, input logic [18:0] ea, input logic [2:0] eo,
                              input logic ee);
    vec_t t;
    t.rst = r; t.req = req; t.gnt = g; t.rv = rv;
    t.e_gnt = eg; t.e_valid = ev; t.e_mreq = em; t.a_chk = ac;
    t.e_addr = ea; t.e_outst = eo; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs 1 ns after the edge, leave 3 ns to settle before sampling
  task automatic drive(input logic r, input logic [3:0] req, input logic g, input logic rv,
                       input logic [3:0] pr, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    rst              = r;
    bus.ch_req_i     = req;
    bus.mem_gnt_i    = g;
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = rdata;
`ifdef UDMA_TX_SCHED_PRIO_EN
    bus.ch_prio_i    = pr;
`else
    if (pr != 4'b0000) $display("note: priority flags ignored in this build");
`endif
    #3;
  endtask

  initial begin
    bus.ch_addr_i    = {A3, A2, A1, A0};
    bus.ch_req_i     = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
`ifdef UDMA_TX_SCHED_PRIO_EN
    bus.ch_prio_i    = '0;
`endif

    //          rst req     g  rv  e_gnt   e_valid em ac addr  outst err
    // single channel: grant ch2, return three cycles later
    v.push_back(mk(0, 4'b0100, 1, 0, 4'b0100, 4'b0000, 1, 1, A2,   3'd0, 0)); // 0
    v.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, '0,   3'd1, 0));
    v.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, '0,   3'd1, 0));
    v.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 4'b0100, 0, 0, '0,   3'd1, 0));
    // reset with everything requesting: all outputs zero
    v.push_back(mk(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 1, '0,   3'd0, 0)); // 4
    // fairness: 0,1,2,3,0,1 with returns steered in the same order
    v.push_back(mk(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 1, A0,   3'd0, 0)); // 5
    v.push_back(mk(0, 4'b1111, 1, 0, 4'b0010, 4'b0000, 1, 1, A1,   3'd1, 0));
    v.push_back(mk(0, 4'b1111, 1, 1, 4'b0100, 4'b0001, 1, 1, A2,   3'd2, 0));
    v.push_back(mk(0, 4'b1111, 1, 1, 4'b1000, 4'b0010, 1, 1, A3,   3'd2, 0));
    v.push_back(mk(0, 4'b1111, 1, 1, 4'b0001, 4'b0100, 1, 1, A0,   3'd2, 0));
    v.push_back(mk(0, 4'b1111, 1, 1, 4'b0010, 4'b1000, 1, 1, A1,   3'd2, 0)); // 10
    // fill to MAX_OUTST with no returns
    v.push_back(mk(0, 4'b1111, 1, 0, 4'b0100, 4'b0000, 1, 1, A2,   3'd2, 0));
    v.push_back(mk(0, 4'b1111, 1, 0, 4'b1000, 4'b0000, 1, 1, A3,   3'd3, 0));
    v.push_back(mk(0, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, '0,   3'd4, 0));
    // full: a return in the same cycle does not unblock the request
    v.push_back(mk(0, 4'b1111, 1, 1, 4'b0000, 4'b0001, 0, 0, '0,   3'd4, 0));
    v.push_back(mk(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 1, A0,   3'd3, 0)); // 15
    // drain in issue order: 1,2,3,0
    v.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 4'b0010, 0, 0, '0,   3'd4, 0));
    v.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 4'b0100, 0, 0, '0,   3'd3, 0));
    v.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 4'b1000, 0, 0, '0,   3'd2, 0));
    v.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 4'b0001, 0, 0, '0,   3'd1, 0));
    // return with nothing in flight: dropped, error becomes sticky
    v.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0, '0,   3'd0, 0)); // 20
    v.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, '0,   3'd0, 1));
    // two reads in flight, then reset
    v.push_back(mk(0, 4'b0011, 1, 0, 4'b0010, 4'b0000, 1, 1, A1,   3'd0, 1));
    v.push_back(mk(0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 1, 1, A0,   3'd1, 1));
    v.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, '0,   3'd0, 0));
    // returns after reset are errors
    v.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0, '0,   3'd0, 0)); // 25
    v.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, '0,   3'd0, 1));

    repeat (2) @(posedge clk);

    foreach (v[i]) begin
      logic [31:0] rd;
      rd = 32'hD000_0000 + 32'(i);
      drive(v[i].rst, v[i].req, v[i].gnt, v[i].rv, 4'b0000, rd);
      chk($sformatf("v%0d gnt", i),    32'(bus.ch_gnt_o),   32'(v[i].e_gnt));
      chk($sformatf("v%0d valid", i),  32'(bus.ch_valid_o), 32'(v[i].e_valid));
      chk($sformatf("v%0d mreq", i),   32'(bus.mem_req_o),  32'(v[i].e_mreq));
      chk($sformatf("v%0d outst", i),  32'(bus.outst_o),    32'(v[i].e_outst));
      chk($sformatf("v%0d err", i),    32'(bus.err_o),      32'(v[i].e_err));
      chk($sformatf("v%0d data", i),   bus.ch_data_o,       v[i].rst ? 32'h0 : rd);
      if (v[i].a_chk)
        chk($sformatf("v%0d addr", i), 32'(bus.mem_addr_o), 32'(v[i].e_addr));
    end

    // Lock: ch1 waits for grant while ch0 joins; address stays on ch1
    drive(1, 4'b0000, 0, 0, 4'b0000, 0);
    drive(0, 4'b0010, 0, 0, 4'b0000, 0);
    chk("lock c0 addr", 32'(bus.mem_addr_o), 32'(A1));
    chk("lock c0 mreq", 32'(bus.mem_req_o), 32'd1);
    chk("lock c0 gnt",  32'(bus.ch_gnt_o),  32'd0);
    drive(0, 4'b0011, 0, 0, 4'b0000, 0);
    chk("lock c1 addr", 32'(bus.mem_addr_o), 32'(A1));
    drive(0, 4'b0011, 0, 0, 4'b0000, 0);
    chk("lock c2 addr", 32'(bus.mem_addr_o), 32'(A1));
    drive(0, 4'b0011, 1, 0, 4'b0000, 0);
    chk("lock c3 gnt",  32'(bus.ch_gnt_o),  32'b0010);
    chk("lock c3 addr", 32'(bus.mem_addr_o), 32'(A1));
    // pointer now at 2: with ch0..ch2 requesting, ch2 wins
    drive(0, 4'b0111, 1, 0, 4'b0000, 0);
    chk("lock rr gnt",  32'(bus.ch_gnt_o),  32'b0100);
    // ch0 gets locked, then drops; ch3 is picked in the same cycle
    drive(0, 4'b0001, 0, 0, 4'b0000, 0);
    chk("drop c0 addr", 32'(bus.mem_addr_o), 32'(A0));
    drive(0, 4'b1000, 0, 0, 4'b0000, 0);
    chk("drop c1 addr", 32'(bus.mem_addr_o), 32'(A3));
    chk("drop c1 mreq", 32'(bus.mem_req_o), 32'd1);
    drive(0, 4'b1000, 1, 0, 4'b0000, 0);
    chk("drop c2 gnt",  32'(bus.ch_gnt_o),  32'b1000);
    chk("drop c2 outst", 32'(bus.outst_o),  32'd2);

`ifdef UDMA_TX_SCHED_PRIO_EN
    // Priority: ch3 flagged beats ch0 despite rr_ptr=0
    drive(1, 4'b0000, 0, 0, 4'b0000, 0);
    drive(0, 4'b1001, 1, 0, 4'b1000, 0);
    chk("prio c0 gnt", 32'(bus.ch_gnt_o), 32'b1000);
    drive(0, 4'b0001, 1, 0, 4'b1000, 0);
    chk("prio c1 gnt", 32'(bus.ch_gnt_o), 32'b0001);
`endif

    drive(0, 4'b0000, 0, 0, 4'b0000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
